// File: rtl/queue_rd_sched_if.sv
// Handshake bundle between the read scheduler and the queue bank / egress side.
// master = scheduler (drives read strobes and grant status), slave = queue bank / egress.
interface queue_rd_sched_if #(
    parameter int NUM_Q     = 4,
    parameter int FIFO_SIZE = 64
);
    localparam int CW = $clog2(FIFO_SIZE) + 1;
    localparam int IW = $clog2(NUM_Q);

    logic [NUM_Q*CW-1:0] q_cnt;
    logic                arb_en;
    logic                out_ready;
    logic [NUM_Q-1:0]    rd_en;
    logic [NUM_Q-1:0]    grant;
    logic [IW-1:0]       grant_id;
    logic                busy;
    logic                burst_done;

    modport master (
        input  q_cnt, arb_en, out_ready,
        output rd_en, grant, grant_id, busy, burst_done
    );

    modport slave (
        output q_cnt, arb_en, out_ready,
        input  rd_en, grant, grant_id, busy, burst_done
    );
endinterface

// File: rtl/queue_rd_sched.sv
// Round-robin read scheduler: grants one non-empty queue for a bounded burst and
// issues one-hot read strobes to that queue and its occupancy counter.
module queue_rd_sched #(
    parameter int NUM_Q     = 4,
    parameter int FIFO_SIZE = 64,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    queue_rd_sched_if.master  bus
);
    localparam int CW = $clog2(FIFO_SIZE) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(NUM_Q);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    gid_q, gid_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [NUM_Q-1:0] grant_q, grant_d;
    logic             done_q, done_d;

    logic [NUM_Q-1:0] req;
    logic [IW-1:0]    winner;
    logic             any_req;
    logic [CW-1:0]    cnt_g;
    logic             rd_fire;
    logic             burst_end;

    always_comb begin
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            req[i] = bus.q_cnt[i*CW +: CW] != '0;
        end
    end

    // Rotating priority search starting at rr_ptr; first hit wins.
    always_comb begin
        int unsigned idx;
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NUM_Q; k++) begin
            idx = (32'(rr_ptr_q) + k) % 32'(NUM_Q);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = IW'(idx);
            end
        end
    end

    assign cnt_g   = bus.q_cnt[gid_q*CW +: CW];
    assign rd_fire = (state_q == XFER) && bus.arb_en && bus.out_ready && (cnt_g != '0);

    assign burst_end = (state_q == XFER) &&
                       (!bus.arb_en || (cnt_g == '0) ||
                        (rd_fire && ((beat_q == BW'(MAX_BURST - 1)) || (cnt_g == CW'(1)))));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        beat_d   = beat_q;
        grant_d  = grant_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.arb_en && any_req) begin
                    state_d         = XFER;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    gid_d           = winner;
                    beat_d          = '0;
                end
            end
            XFER: begin
                if (burst_end) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = IW'((32'(gid_q) + 32'd1) % 32'(NUM_Q));
                    done_d   = 1'b1;
                end else if (rd_fire) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            beat_q   <= '0;
            grant_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            beat_q   <= beat_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
        end
    end

    // Read strobe comes from registered state, so it drops as soon as reset clears state_q.
    assign bus.rd_en      = rd_fire ? grant_q : '0;
    assign bus.grant      = grant_q;
    assign bus.grant_id   = gid_q;
    assign bus.busy       = (state_q == XFER);
    assign bus.burst_done = done_q;
endmodule

// File: tb/tb_queue_rd_sched.sv
// Scoreboard bench for queue_rd_sched: stimulus queues expected reads/burst ends,
// a negedge monitor pops and compares whenever the DUT strobes rd_en or burst_done.
module tb_queue_rd_sched;
    localparam int NUM_Q     = 4;
    localparam int FIFO_SIZE = 64;
    localparam int MAX_BURST = 8;
    localparam int CW        = $clog2(FIFO_SIZE) + 1;

    typedef struct {
        int         rel;
        logic [3:0] rd;
        int         gid;
    } rd_exp_t;

    typedef struct {
        int rel;
        int gid;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    queue_rd_sched_if #(.NUM_Q(NUM_Q), .FIFO_SIZE(FIFO_SIZE)) bus ();

    queue_rd_sched #(
        .NUM_Q    (NUM_Q),
        .FIFO_SIZE(FIFO_SIZE),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    rd_exp_t   rdq[$];
    done_exp_t doneq[$];
    int        cnt[NUM_Q];
    int        cyc  = 0;
    int        base = 0;
    int        tests = 0;
    int        fails = 0;
    logic [6:0] stall_pat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NUM_Q; i++) bus.q_cnt[i*CW +: CW] = CW'(cnt[i]);
    endtask

    // Advance one clock; the bench stands in for the occupancy counters.
    task automatic tick();
        logic [NUM_Q-1:0] rd;
        #3;
        rd = bus.rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_Q; i++) if (rd[i]) cnt[i]--;
        pack();
    endtask

    task automatic exp_rd(input int rel, input logic [3:0] rd, input int gid);
        rd_exp_t e;
        e.rel = rel; e.rd = rd; e.gid = gid;
        rdq.push_back(e);
    endtask

    task automatic exp_done(input int rel, input int gid);
        done_exp_t e;
        e.rel = rel; e.gid = gid;
        doneq.push_back(e);
    endtask

    rd_exp_t   mon_rd;
    done_exp_t mon_done;
    int        mon_rel;

    always @(negedge clk) begin
        mon_rel = cyc - base;
        if (bus.rd_en !== '0) begin
            if (rdq.size() == 0) begin
                check("unexpected_read", 32'(bus.rd_en), 32'd0);
            end else begin
                mon_rd = rdq.pop_front();
                check("read_cycle", 32'(mon_rel), 32'(mon_rd.rel));
                check("read_mask", 32'(bus.rd_en), 32'(mon_rd.rd));
                check("read_gid", 32'(bus.grant_id), 32'(mon_rd.gid));
                check("rd_within_grant", 32'(bus.rd_en & ~bus.grant), 32'd0);
            end
        end
        if (bus.burst_done !== 1'b0) begin
            if (doneq.size() == 0) begin
                check("unexpected_burst_done", 32'(bus.burst_done), 32'd0);
            end else begin
                mon_done = doneq.pop_front();
                check("done_cycle", 32'(mon_rel), 32'(mon_done.rel));
                check("done_gid", 32'(bus.grant_id), 32'(mon_done.gid));
                check("done_busy_low", 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        rst_n         = 1'b1;
        bus.arb_en    = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_Q; i++) cnt[i] = 0;
        pack();
        #1 rst_n = 1'b0;
        #1;
        check("reset_rd_en", 32'(bus.rd_en), 32'd0);
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_grant_id", 32'(bus.grant_id), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_burst_done", 32'(bus.burst_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Round robin: all queues hold 3, pointer at 0.
        bus.arb_en = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_Q; i++) cnt[i] = 3;
        pack();
        base = cyc;
        for (int g = 0; g < 4; g++) begin
            for (int r = 1; r <= 3; r++) exp_rd(4*g + r, 4'(1 << g), g);
            exp_done(4*g + 4, g);
        end
        repeat (18) tick();
        check("rr_idle_busy", 32'(bus.busy), 32'd0);
        check("rr_idle_grant", 32'(bus.grant), 32'd0);

        // Single queue 1 with 20 words: bursts of 8, 8, 4.
        cnt[1] = 20; pack();
        base = cyc;
        for (int r = 1;  r <= 8;  r++) exp_rd(r, 4'b0010, 1);
        exp_done(9, 1);
        for (int r = 10; r <= 17; r++) exp_rd(r, 4'b0010, 1);
        exp_done(18, 1);
        for (int r = 19; r <= 22; r++) exp_rd(r, 4'b0010, 1);
        exp_done(23, 1);
        repeat (25) tick();

        // Stall: queue 2 with 5 words, out_ready 1,0,0,1,1,1,1.
        stall_pat = 7'b1111001;
        cnt[2] = 5; pack();
        base = cyc;
        exp_rd(1, 4'b0100, 2);
        for (int r = 4; r <= 7; r++) exp_rd(r, 4'b0100, 2);
        exp_done(8, 2);
        for (int r = 1; r <= 7; r++) begin
            tick();
            bus.out_ready = stall_pat[r-1];
            if (!bus.out_ready) begin
                #1;
                check("stall_grant_held", 32'(bus.grant), 32'h4);
                check("stall_no_read", 32'(bus.rd_en), 32'd0);
            end
        end
        repeat (3) tick();

        // External drain: queue 0 granted while stalled, count forced to 0.
        bus.out_ready = 1'b0;
        cnt[0] = 4; pack();
        base = cyc;
        exp_done(3, 0);
        tick();
        #1;
        check("drain_grant", 32'(bus.grant), 32'h1);
        check("drain_busy", 32'(bus.busy), 32'd1);
        tick();
        cnt[0] = 0; pack();
        bus.out_ready = 1'b1;
        #1;
        check("drain_no_read", 32'(bus.rd_en), 32'd0);
        repeat (3) tick();

        // Abort on queue 3, then queue 1 burst, then reset mid-burst on queue 3.
        cnt[3] = 6; pack();
        base = cyc;
        exp_rd(1, 4'b1000, 3);
        exp_rd(2, 4'b1000, 3);
        exp_done(4, 3);
        tick(); tick(); tick();
        bus.arb_en = 1'b0;
        #1;
        check("abort_no_read", 32'(bus.rd_en), 32'd0);
        check("abort_still_busy", 32'(bus.busy), 32'd1);
        tick();
        check("abort_end_busy", 32'(bus.busy), 32'd0);
        for (int r = 5; r <= 7; r++) begin
            tick();
            check("arb_off_busy", 32'(bus.busy), 32'd0);
            check("arb_off_grant", 32'(bus.grant), 32'd0);
        end
        tick();
        bus.arb_en = 1'b1;
        cnt[1] = 2; pack();
        exp_rd(9,  4'b0010, 1);
        exp_rd(10, 4'b0010, 1);
        exp_done(11, 1);
        exp_rd(12, 4'b1000, 3);
        exp_rd(13, 4'b1000, 3);
        repeat (6) tick();
        #1 rst_n = 1'b0;
        #1;
        check("midreset_rd_en", 32'(bus.rd_en), 32'd0);
        check("midreset_grant", 32'(bus.grant), 32'd0);
        check("midreset_grant_id", 32'(bus.grant_id), 32'd0);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_burst_done", 32'(bus.burst_done), 32'd0);
        cnt[0] = 1; pack();
        tick(); tick();
        rst_n = 1'b1;
        base = cyc;
        exp_rd(1, 4'b0001, 0);
        exp_done(2, 0);
        exp_rd(3, 4'b1000, 3);
        exp_rd(4, 4'b1000, 3);
        exp_done(5, 3);
        repeat (8) tick();

        check("pending_reads", 32'(rdq.size()), 32'd0);
        check("pending_burst_done", 32'(doneq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/queue_rd_sched.md
# queue_rd_sched

Read-side scheduler for a bank of NUM_Q output queues, each tracked by an occupancy counter. It arbitrates round-robin among non-empty queues. The winning queue is granted for a bounded burst, and the scheduler issues one-hot read strobes that drive both the queue read port and its occupancy counter's rd_en. It sits between the queue bank and the downstream egress/port logic, which throttles reads with out_ready.

## Interface
- NUM_Q, 4: number of queues arbitrated (≥2).
- FIFO_SIZE, 64: queue depth. Count width CW = $clog2(FIFO_SIZE)+1.
- MAX_BURST, 8: maximum reads per grant (≥1). Beat counter width BW = $clog2(MAX_BURST+1).
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- q_cnt  input  NUM_Q*CW  flattened occupancy counts. Queue i occupies bits [i*CW +: CW].
- arb_en  input  1  scheduler enable. When low, no new grant is made and no rd_en is issued.
- out_ready  input  1  downstream can accept one word this cycle.
- rd_en  output  NUM_Q  one-hot read strobe to the granted queue and its counter.
- grant  output  NUM_Q  registered one-hot grant. All zeros when not in XFER.
- grant_id  output  $clog2(NUM_Q)  binary index of the current/last granted queue.
- busy  output  1  high while in XFER.
- burst_done  output  1  one-cycle registered pulse after a burst ends.

## Operation
- Internal state: state ∈ {IDLE, XFER}, rr_ptr (binary, NUM_Q range), beat_cnt (BW bits).
- A request exists for queue i when cnt_i != 0.
- cnt_g denotes the count of the granted queue.
- **IDLE:**
  - Transition: if arb_en and any request, go to XFER.
  - Winner: the first requesting queue found searching from rr_ptr upward with modulo-NUM_Q wrap.
  - On the transition: grant ← one-hot(winner), grant_id ← winner, beat_cnt ← 0.
- **XFER read rule:** rd_en = grant when arb_en && out_ready && cnt_g != 0. Otherwise rd_en = 0.
  - rd_en is combinational from registered state and these inputs. The counter decrements on the same edge.
  - beat_cnt increments on every issued read.
- **Burst end.** XFER returns to IDLE on the edge where any of these holds:
  - a read is issued with beat_cnt == MAX_BURST-1 (burst limit);
  - a read is issued with cnt_g == 1 (queue drained);
  - cnt_g == 0 (queue emptied externally; no read issued);
  - arb_en == 0 (abort; no read issued).
- **On every burst end:**
  - grant ← 0;
  - rr_ptr ← (grant_id+1) mod NUM_Q;
  - burst_done ← 1 for exactly one cycle;
  - grant_id holds its value.
- out_ready low in XFER stalls the burst. The grant is held, beat_cnt does not change, and there is no timeout.
- Fairness: every non-empty queue is granted within NUM_Q-1 intervening bursts.
- rd_en is never asserted for a queue whose count is 0, and never for more than one queue.

## Timing
- Reset values: state IDLE, rr_ptr 0, beat_cnt 0, grant 0, grant_id 0, busy 0, burst_done 0, rd_en 0.
- Reset asserted mid-burst clears the state immediately, and rd_en drops combinationally with no clock.
- Latency from request to first read:
  - a request visible in IDLE on edge N gives grant/busy high after edge N;
  - the first rd_en occurs in that same cycle if out_ready is high.
- Throughput: with out_ready held high, a burst issues one read per cycle.
- Inter-burst gap: exactly one IDLE cycle, in which burst_done is high.
- burst_done is registered and is high in the cycle after the final XFER cycle.
- grant and rd_en share the granted bit position. rd_en ⊆ grant at all times.

## Test plan
- **Single queue, long burst:** NUM_Q=4, MAX_BURST=8, cnt_1=20, others 0, out_ready=1.
  - Burst of 8 reads on rd_en[1] in 8 consecutive cycles, then burst_done, then a one-cycle gap.
  - Then 8 more reads, then a final burst of 4 reads.
- **Round-robin order:** all counts = 3, rr_ptr=0.
  - Grants run 0,1,2,3, each with 3 reads.
  - grant_id sequence is 0,1,2,3. rr_ptr wraps to 0.
- **Stall:** cnt_2=5, with out_ready toggled 1,0,0,1,1,1,1.
  - rd_en[2] follows out_ready exactly; grant is held throughout.
  - burst_done comes after the 5th read; beat_cnt is not advanced during stalls.
- **External drain:** during a burst, cnt_g is forced from 4 to 0 with no read.
  - Next edge returns to IDLE with burst_done=1 and no rd_en issued.
- **Abort and reset:**
  - arb_en dropped mid-burst gives rd_en=0 that cycle, burst end next edge, and no new grant while low.
  - rst_n pulsed low mid-burst clears all outputs to 0 immediately. After release, arbitration restarts from queue 0.
